// File: rtl/spi_cmd_ctrl_pkg.sv
// rtl/spi_cmd_ctrl_pkg.sv - shared types and constants for the SPI command sequencer
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_DATA  = 2'd1,
    EXEC     = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  localparam logic [6:0]  ADDR_STATUS = 7'd0;
  localparam logic [6:0]  ADDR_CTRL   = 7'h7F;
  localparam logic [15:0] RD_INVALID  = 16'hDEAD;

  // Command word layout: write flag, 7-bit address, low byte reserved.
  localparam int CMD_WR_BIT   = 15;
  localparam int CMD_ADDR_MSB = 14;
  localparam int CMD_ADDR_LSB = 8;

  // CTRL data word bits.
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  function automatic logic [15:0] status_word(input logic err, input logic done, input logic busy);
    return {13'b0, err, done, busy};
  endfunction

endpackage

// File: rtl/spi_frame_sync.sv
// rtl/spi_frame_sync.sv - brings completed SPI frames from the sclk domain into clk
module spi_frame_sync #(
  parameter int DATA_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frm_valid,
  input  logic [DATA_SIZE-1:0] frm_data,
  output logic                 frm_evt,
  output logic [DATA_SIZE-1:0] frm_word
);

  logic sync_a;
  logic sync_b;
  logic sync_q;
  logic armed;
  logic rise;

  // The reset value of the synchroniser is not a real observation of the line,
  // so arming waits for a genuine high-to-low transition; this discards the
  // edge produced when the idle-high level first propagates after reset.
  assign rise = sync_b & ~sync_q & armed;

  // Two-flop synchroniser, edge history, arming and data capture.
  // frm_data is held for many sclk periods after frm_valid rises, so it is
  // sampled directly on the edge that raises frm_evt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a   <= 1'b0;
      sync_b   <= 1'b0;
      sync_q   <= 1'b0;
      armed    <= 1'b0;
      frm_evt  <= 1'b0;
      frm_word <= '0;
    end else begin
      sync_a  <= frm_valid;
      sync_b  <= sync_a;
      sync_q  <= sync_b;
      if (sync_q && !sync_b) begin
        armed <= 1'b1;
      end
      frm_evt <= rise;
      if (rise) begin
        frm_word <= frm_data;
      end
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// rtl/spi_cmd_ctrl.sv - decodes two-frame SPI transactions into register and accelerator actions
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int FPGA_CLK       = 12_000_000,
  parameter int SPI_CLK        = 1_000_000,
  parameter int DATA_SIZE      = 16,
  parameter int NUM_REGS       = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frm_valid,
  input  logic [DATA_SIZE-1:0]          frm_data,
  output logic [DATA_SIZE-1:0]          tx_data,
  output logic [NUM_REGS*DATA_SIZE-1:0] cfg_regs,
  output logic                          cfg_wr,
  output logic [6:0]                    cfg_wr_addr,
  output logic                          acc_start,
  input  logic                          acc_busy,
  input  logic                          acc_done,
  output logic                          err
);

  if (DATA_SIZE != 16) begin : g_bad_data_size
    $error("spi_cmd_ctrl: DATA_SIZE must be 16");
  end
  if (NUM_REGS < 1 || NUM_REGS > 127) begin : g_bad_num_regs
    $error("spi_cmd_ctrl: NUM_REGS must be 1..127");
  end
  if (FPGA_CLK < 4 * SPI_CLK) begin : g_bad_clk_ratio
    $error("spi_cmd_ctrl: FPGA_CLK must be at least 4*SPI_CLK");
  end

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  function automatic logic is_reg_addr(input logic [6:0] a);
    return (a != ADDR_STATUS) && (32'(a) < NUM_REGS);
  endfunction

  logic                 frm_evt;
  logic [DATA_SIZE-1:0] frm_word;
  state_t               state;
  state_t               state_next;
  logic [6:0]           addr_q;
  logic [1:0]           ctrl_q;
  logic [TW-1:0]        tmo_cnt;
  logic                 timeout;
  logic                 done_sticky;
  logic                 err_set;
  logic                 flags_clr;
  logic                 cmd_write;
  logic [6:0]           cmd_addr;
  logic [DATA_SIZE-1:0] rd_value;
  logic [DATA_SIZE-1:0] regs [NUM_REGS];

  spi_frame_sync #(
    .DATA_SIZE(DATA_SIZE)
  ) u_frame_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .frm_valid(frm_valid),
    .frm_data (frm_data),
    .frm_evt  (frm_evt),
    .frm_word (frm_word)
  );

  assign cmd_write = frm_word[CMD_WR_BIT];
  assign cmd_addr  = frm_word[CMD_ADDR_MSB:CMD_ADDR_LSB];
  assign timeout   = ((state == WR_DATA) || (state == RD_DRAIN)) && (tmo_cnt == TMO_LIMIT);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_regs[g*DATA_SIZE +: DATA_SIZE] = regs[g];
  end

  // Read value for the command currently presented by the frame synchroniser.
  always_comb begin
    rd_value = RD_INVALID;
    if (cmd_addr == ADDR_STATUS) begin
      rd_value = status_word(err, done_sticky, acc_busy);
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (cmd_addr == 7'(i)) begin
          rd_value = regs[i];
        end
      end
    end
  end

  // Next-state logic plus the single-cycle EXEC outputs.
  always_comb begin
    state_next  = state;
    cfg_wr      = 1'b0;
    cfg_wr_addr = 7'd0;
    acc_start   = 1'b0;
    err_set     = 1'b0;
    flags_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (frm_evt) begin
          state_next = cmd_write ? WR_DATA : RD_DRAIN;
        end
      end
      WR_DATA: begin
        if (frm_evt) begin
          state_next = EXEC;
        end else if (timeout) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end
      end
      EXEC: begin
        state_next = IDLE;
        if (is_reg_addr(addr_q)) begin
          cfg_wr      = 1'b1;
          cfg_wr_addr = addr_q;
        end else if (addr_q == ADDR_CTRL) begin
          if (ctrl_q[CTRL_START_BIT]) begin
            if (acc_busy) begin
              err_set = 1'b1;
            end else begin
              acc_start = 1'b1;
            end
          end
          flags_clr = ctrl_q[CTRL_CLEAR_BIT];
        end else if (addr_q != ADDR_STATUS) begin
          err_set = 1'b1;
        end
      end
      RD_DRAIN: begin
        if (frm_evt || timeout) begin
          state_next = IDLE;
          err_set    = !frm_evt;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, transaction latches, timeout counter and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= 7'd0;
      ctrl_q      <= 2'd0;
      tmo_cnt     <= '0;
      err         <= 1'b0;
      done_sticky <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        tmo_cnt <= '0;
      end else if (((state == WR_DATA) || (state == RD_DRAIN)) && (tmo_cnt != TMO_LIMIT)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (state == IDLE && frm_evt && cmd_write) begin
        addr_q <= cmd_addr;
      end
      if (state == WR_DATA && frm_evt) begin
        ctrl_q <= frm_word[1:0];
      end
      err         <= err_set | (err & ~flags_clr);
      done_sticky <= acc_done | (done_sticky & ~flags_clr);
    end
  end

  // Register file: written as the data frame is accepted, so the new value is
  // already visible while cfg_wr is high in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state == WR_DATA && frm_evt && is_reg_addr(addr_q)) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (addr_q == 7'(i)) begin
          regs[i] <= frm_word;
        end
      end
    end
  end

  // MISO word: loaded on a read command, cleared when the read transaction ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data <= '0;
    end else if (state == IDLE && frm_evt && !cmd_write) begin
      tx_data <= rd_value;
    end else if (state == RD_DRAIN && (frm_evt || timeout)) begin
      tx_data <= '0;
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb/tb_spi_cmd_ctrl.sv - randomized self-checking bench for spi_cmd_ctrl
module tb_spi_cmd_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frm_valid;
  logic [15:0]  frm_data;
  logic [15:0]  tx_data;
  logic [127:0] cfg_regs;
  logic         cfg_wr;
  logic [6:0]   cfg_wr_addr;
  logic         acc_start;
  logic         acc_busy;
  logic         acc_done;
  logic         err;

  int checks = 0;
  int failures = 0;

  // Reference state derived from the command semantics.
  logic [15:0] m_regs [8];
  logic        m_err;
  logic        m_done;

  int          wr_cnt = 0;
  int          start_cnt = 0;
  logic [6:0]  last_wr_addr = 7'd0;

  spi_cmd_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frm_valid  (frm_valid),
    .frm_data   (frm_data),
    .tx_data    (tx_data),
    .cfg_regs   (cfg_regs),
    .cfg_wr     (cfg_wr),
    .cfg_wr_addr(cfg_wr_addr),
    .acc_start  (acc_start),
    .acc_busy   (acc_busy),
    .acc_done   (acc_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_wr) begin
      wr_cnt++;
      last_wr_addr = cfg_wr_addr;
    end
    if (acc_start) start_cnt++;
  end

  function automatic logic [15:0] model_read(input logic [6:0] a);
    if (a == 7'd0) return {13'b0, m_err, m_done, acc_busy};
    if (a < 7'd8) return m_regs[a[2:0]];
    return 16'hDEAD;
  endfunction

  function automatic logic [127:0] model_flat();
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_err = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] w);
    @(negedge clk);
    frm_valid = 1'b0;
    repeat (8) @(negedge clk);
    frm_data = w;
    repeat (4) @(negedge clk);
    frm_valid = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
  endtask

  task automatic do_write(input string name, input logic [6:0] a, input logic [15:0] d);
    int wr0, st0, exp_wr, exp_st;
    logic set;
    wr0 = wr_cnt;
    st0 = start_cnt;
    exp_wr = 0;
    exp_st = 0;
    send_frame({1'b1, a, 8'($urandom)});
    send_frame(d);
    if (a >= 7'd1 && a < 7'd8) begin
      m_regs[a[2:0]] = d;
      exp_wr = 1;
    end else if (a == 7'h7F) begin
      set = d[0] && acc_busy;
      exp_st = (d[0] && !acc_busy) ? 1 : 0;
      if (d[1]) begin
        m_err = 1'b0;
        m_done = 1'b0;
      end
      if (set) m_err = 1'b1;
    end else if (a != 7'd0) begin
      m_err = 1'b1;
    end
    checks++;
    if (wr_cnt - wr0 !== exp_wr) begin
      failures++;
      $display("FAIL %s cfg_wr count: got %0d expected %0d", name, wr_cnt - wr0, exp_wr);
    end
    if (exp_wr == 1) begin
      checks++;
      if (last_wr_addr !== a) begin
        failures++;
        $display("FAIL %s cfg_wr_addr: got %0h expected %0h", name, last_wr_addr, a);
      end
    end
    checks++;
    if (start_cnt - st0 !== exp_st) begin
      failures++;
      $display("FAIL %s acc_start count: got %0d expected %0d", name, start_cnt - st0, exp_st);
    end
    checks++;
    if (err !== m_err) begin
      failures++;
      $display("FAIL %s err: got %b expected %b", name, err, m_err);
    end
    checks++;
    if (cfg_regs !== model_flat()) begin
      failures++;
      $display("FAIL %s cfg_regs: got %h expected %h", name, cfg_regs, model_flat());
    end
  endtask

  task automatic do_read(input string name, input logic [6:0] a);
    logic [15:0] exp;
    send_frame({1'b0, a, 8'($urandom)});
    exp = model_read(a);
    checks++;
    if (tx_data !== exp) begin
      failures++;
      $display("FAIL %s tx_data read addr %0h: got %h expected %h", name, a, tx_data, exp);
    end
    send_frame(16'($urandom));
    checks++;
    if (tx_data !== 16'h0) begin
      failures++;
      $display("FAIL %s tx_data after dummy: got %h expected 0000", name, tx_data);
    end
  endtask

  task automatic test_reset();
    frm_valid = 1'b1;
    frm_data = 16'h8300;
    acc_busy = 1'b0;
    acc_done = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_data, cfg_wr, cfg_wr_addr, acc_start, err} !== 26'h0 || cfg_regs !== 128'h0) begin
      failures++;
      $display("FAIL reset outputs: tx=%h wr=%b addr=%h start=%b err=%b regs=%h expected all zero",
               tx_data, cfg_wr, cfg_wr_addr, acc_start, err, cfg_regs);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    // The post-reset rise with 0x8300 on the bus must not start a write, so
    // the next frame is a read command for address 0x12.
    do_read("post_reset_ignore", 7'h12);
    checks++;
    if (wr_cnt !== 0 || cfg_regs !== 128'h0) begin
      failures++;
      $display("FAIL post_reset_ignore write: got wr_cnt=%0d regs=%h expected 0", wr_cnt, cfg_regs);
    end
  endtask

  task automatic test_write_read();
    do_write("write_reg3", 7'd3, 16'h1234);
    do_read("read_reg3", 7'd3);
  endtask

  task automatic test_ctrl();
    acc_busy = 1'b0;
    do_write("ctrl_start_idle", 7'h7F, 16'h0001);
    acc_busy = 1'b1;
    do_write("ctrl_start_busy", 7'h7F, 16'h0001);
    acc_busy = 1'b0;
    do_write("ctrl_clear", 7'h7F, 16'h0002);
  endtask

  task automatic test_invalid();
    do_read("read_invalid", 7'h20);
    do_write("write_invalid", 7'h20, 16'hBEEF);
    do_write("clear_invalid", 7'h7F, 16'h0002);
  endtask

  task automatic test_timeout();
    send_frame(16'h8100);
    repeat (4000) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL wr_timeout early: got err=%b expected 0", err);
    end
    repeat (200) @(negedge clk);
    m_err = 1'b1;
    checks++;
    if (err !== 1'b1 || wr_cnt == 0 && 1'b0) begin
      failures++;
      $display("FAIL wr_timeout: got err=%b expected 1", err);
    end
    do_read("after_wr_timeout", 7'd1);
    do_write("clear_after_timeout", 7'h7F, 16'h0002);
    send_frame(16'h0300);
    repeat (4200) @(negedge clk);
    m_err = 1'b1;
    checks++;
    if (err !== 1'b1 || tx_data !== 16'h0) begin
      failures++;
      $display("FAIL rd_timeout: got err=%b tx=%h expected err=1 tx=0000", err, tx_data);
    end
    do_write("clear_rd_timeout", 7'h7F, 16'h0002);
  endtask

  task automatic test_done();
    @(negedge clk);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    m_done = 1'b1;
    do_read("status_done", 7'd0);
    do_write("clear_done", 7'h7F, 16'h0002);
    do_read("status_cleared", 7'd0);
  endtask

  task automatic test_reset_mid();
    do_write("pre_reset_write", 7'd5, 16'hA5A5);
    send_frame({1'b1, 7'd2, 8'h00});
    apply_reset();
    // With the write command lost, this data word is taken as a read of 0x3F.
    do_read("reset_mid", 7'h3F);
    checks++;
    if (cfg_regs !== 128'h0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid state: got regs=%h err=%b expected 0", cfg_regs, err);
    end
  endtask

  task automatic test_random();
    logic [6:0] a;
    for (int n = 0; n < 30; n++) begin
      acc_busy = 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        a = ($urandom_range(0, 5) == 0) ? 7'h7F : 7'($urandom_range(1, 9));
        do_write("rand_write", a, 16'($urandom));
      end else begin
        do_read("rand_read", 7'($urandom_range(0, 9)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_ctrl();
    test_invalid();
    test_timeout();
    test_done();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
